// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline control slice.
//   hazstate_t : hazard sequencer states
//   regbits_t  : register-file index
//   REG_ZERO   : hard-wired zero register (never a hazard source)
//   draincnt_t : halt drain countdown, wide enough for HALT_DRAIN up to 7
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  localparam regbits_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    DRAIN,
    HALTED
  } hazstate_t;

  localparam int unsigned DRAIN_W = 3;

  typedef logic [DRAIN_W-1:0] draincnt_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard decode for the hazard sequencer.
// Ports:
//   idrsel1, idrsel2 : ID-stage source registers
//   exMemToReg       : EX-stage instruction is a load
//   exWEN            : EX-stage instruction writes a register
//   exwsel           : EX-stage destination register
//   ex_redirect      : EX resolved a control transfer
//   lu_stall         : load-use hazard between EX load and ID consumer
//   redirect_flush   : younger instructions must be squashed
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic [4:0] idrsel1,
  input  logic [4:0] idrsel2,
  input  logic       exMemToReg,
  input  logic       exWEN,
  input  logic [4:0] exwsel,
  input  logic       ex_redirect,
  output logic       lu_stall,
  output logic       redirect_flush
);

  regbits_t rs_q1, rs_q2, rd_ex;
  logic     src_match;

  assign rs_q1 = regbits_t'(idrsel1);
  assign rs_q2 = regbits_t'(idrsel2);
  assign rd_ex = regbits_t'(exwsel);

  assign src_match = (rd_ex == rs_q1) || (rd_ex == rs_q2);

  always_comb begin
    lu_stall       = exMemToReg && exWEN && (rd_ex != REG_ZERO) && src_match;
    redirect_flush = ex_redirect;
  end

endmodule

// File: rtl/hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Drives latch write enables, synchronous latch flushes and the PC enable,
// resolving data-memory waits, halt drain, redirects, load-use hazards and
// instruction fetch waits (in that priority order).
// Ports:
//   CLK, RST                          : clock, asynchronous active-high reset
//   ihit, dhit                        : instruction / data access complete
//   idrsel1, idrsel2                  : ID-stage source registers
//   exMemToReg, exWEN, exwsel         : EX-stage load / write / destination
//   ex_redirect                       : EX taken branch, jump, JR or JAL
//   memcuDRE, memcuDWE, memcuHALT     : MEM-stage read / write / halt
//   pc_en                             : PC update enable
//   ifW, idW, exW, memW               : pipeline latch write enables
//   ifRST, idRST, exRST, memRST       : pipeline latch synchronous flushes
//   halt                              : processor halted (sticky until RST)
//   stall_cnt, flush_cnt              : saturating performance counters,
//                                       present only with HAZARD_PERF_CNT_EN
module hazard_controller
  import cpu_types_pkg::*;
#(
  parameter int unsigned HALT_DRAIN  = 2,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic [4:0] idrsel1,
  input  logic [4:0] idrsel2,
  input  logic       exMemToReg,
  input  logic       exWEN,
  input  logic [4:0] exwsel,
  input  logic       ex_redirect,
  input  logic       memcuDRE,
  input  logic       memcuDWE,
  input  logic       memcuHALT,
  output logic       pc_en,
  output logic       ifW,
  output logic       idW,
  output logic       exW,
  output logic       memW,
  output logic       ifRST,
  output logic       idRST,
  output logic       exRST,
  output logic       memRST,
  output logic       halt
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [STALL_CNT_W-1:0] flush_cnt
`endif
);

  if ((HALT_DRAIN < 1) || (HALT_DRAIN > 7) || (STALL_CNT_W < 1)) begin : g_bad_param
    $error("hazard_controller: HALT_DRAIN must be 1..7 and STALL_CNT_W >= 1");
  end

  localparam draincnt_t DRAIN_LOAD = draincnt_t'(HALT_DRAIN - 1);

  hazstate_t state_q, state_d;
  draincnt_t cnt_q, cnt_d;

  logic mem_req;
  logic dstall;
  logic halt_det;
  logic lu_stall;
  logic redirect_flush;

  hazard_detect u_detect (
    .idrsel1        (idrsel1),
    .idrsel2        (idrsel2),
    .exMemToReg     (exMemToReg),
    .exWEN          (exWEN),
    .exwsel         (exwsel),
    .ex_redirect    (ex_redirect),
    .lu_stall       (lu_stall),
    .redirect_flush (redirect_flush)
  );

  assign mem_req = memcuDRE | memcuDWE;

  // A stalled cycle freezes everything, so redirect/load-use requests are
  // simply re-presented by the frozen pipe on the dhit cycle.
  assign dstall = ((state_q == RUN) && mem_req && !dhit) ||
                  ((state_q == DWAIT) && !dhit);

  assign halt_det = ((state_q == RUN) || (state_q == DWAIT)) && !dstall && memcuHALT;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // halt rises HALT_DRAIN cycles after detection: the detection cycle counts
  // as the first, so DRAIN lasts HALT_DRAIN-1 cycles and is skipped for 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN, DWAIT: begin
        if (dstall) begin
          state_d = DWAIT;
        end else if (memcuHALT) begin
          state_d = (HALT_DRAIN == 1) ? HALTED : DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= draincnt_t'(1)) begin
          state_d = HALTED;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_en  = 1'b1;
    ifW    = 1'b1;
    idW    = 1'b1;
    exW    = 1'b1;
    memW   = 1'b1;
    ifRST  = 1'b0;
    idRST  = 1'b0;
    exRST  = 1'b0;
    memRST = 1'b0;
    halt   = 1'b0;
    if (RST) begin
      pc_en  = 1'b0;
      ifW    = 1'b0;
      idW    = 1'b0;
      exW    = 1'b0;
      memW   = 1'b0;
      ifRST  = 1'b1;
      idRST  = 1'b1;
      exRST  = 1'b1;
      memRST = 1'b1;
    end else if (state_q == HALTED) begin
      pc_en = 1'b0;
      ifW   = 1'b0;
      idW   = 1'b0;
      exW   = 1'b0;
      memW  = 1'b0;
      halt  = 1'b1;
    end else if (dstall) begin
      pc_en = 1'b0;
      ifW   = 1'b0;
      idW   = 1'b0;
      exW   = 1'b0;
      memW  = 1'b0;
    end else if (halt_det || (state_q == DRAIN)) begin
      pc_en = 1'b0;
      ifRST = 1'b1;
      idRST = 1'b1;
      exRST = 1'b1;
    end else if (redirect_flush) begin
      ifRST = 1'b1;
      idRST = 1'b1;
    end else if (lu_stall) begin
      pc_en = 1'b0;
      ifW   = 1'b0;
      idRST = 1'b1;
    end else if (!ihit) begin
      pc_en = 1'b0;
      ifRST = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!halt) begin
      if (!pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ex_redirect && !dstall && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the write enables (ifW, idW, exW, memW) and synchronous flushes (ifRST, idRST, exRST, memRST) of the four pipeline latches, plus the PC enable. It resolves load-use hazards, taken branches and jumps, instruction/data memory waits, and halt drain. It sits beside the datapath and is fed by the ID, EX and MEM stage fields and by the cache hit lines.

Parameters:
HALT_DRAIN, 2, cycles between MEM-stage halt detection and halt output assertion (range 1..7)
STALL_CNT_W, 32, width of the optional stall/flush counters

Ports:
CLK  in  1  pipeline clock
RST  in  1  asynchronous reset, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
idrsel1  in  5  ID-stage rs
idrsel2  in  5  ID-stage rt
exMemToReg  in  1  EX-stage instruction is a load
exWEN  in  1  EX-stage writes a register
exwsel  in  5  EX-stage destination register
ex_redirect  in  1  EX resolved: taken branch, jmp, JR or JAL
memcuDRE  in  1  MEM-stage data read request
memcuDWE  in  1  MEM-stage data write request
memcuHALT  in  1  MEM-stage halt instruction
pc_en  out  1  PC register update enable
ifW  out  1  IF/ID latch write enable
idW  out  1  ID/EX latch write enable
exW  out  1  EX/MEM latch write enable
memW  out  1  MEM/WB latch write enable
ifRST  out  1  IF/ID synchronous flush
idRST  out  1  ID/EX synchronous flush
exRST  out  1  EX/MEM synchronous flush
memRST  out  1  MEM/WB synchronous flush
halt  out  1  processor halted, sticky

Behaviour:
- Reset: state RUN, drain counter 0, halt=0. While RST is high: all *W=0, all *RST=1, pc_en=0.
- States:
  - RUN: normal operation.
  - DWAIT: data access outstanding.
  - DRAIN: halt seen; counting down.
  - HALTED: terminal.
- Transitions:
  - RUN→DWAIT when (memcuDRE|memcuDWE) & !dhit.
  - DWAIT→RUN on dhit.
  - RUN→DRAIN when memcuHALT, with the counter loaded to HALT_DRAIN-1.
  - DRAIN→HALTED when the counter reaches 0.
  - HALTED stays until RST.
- Output rules are combinational from state and inputs. Priority, highest first:
  1. Data stall (RUN with a pending miss, or DWAIT with !dhit): every *W=0, every *RST=0, pc_en=0. The whole pipe freezes. A concurrent ex_redirect or load-use is held, not lost: it is re-evaluated on the dhit cycle.
  2. Halt: on the memcuHALT cycle and in DRAIN, pc_en=0 and ifRST=idRST=exRST=1. MEM/WB keeps writing so the final writeback completes. In HALTED, all *W=0, pc_en=0, halt=1.
  3. Redirect (ex_redirect=1): pc_en=1 (the PC takes the target), ifRST=1 and idRST=1 squash the two younger instructions, all *W=1.
  4. Load-use (exMemToReg & exWEN & exwsel≠0 & exwsel∈{idrsel1, idrsel2}): pc_en=0, ifW=0 (hold ID), idRST=1 (bubble into EX), exW=memW=1. This is exactly one bubble per hazard; the EX instruction moves on the next cycle, so the hazard clears naturally.
  5. Fetch wait (!ihit): pc_en=0, ifRST=1 (bubble into ID), downstream *W=1.
  6. Otherwise: all *W=1, all *RST=0, pc_en=1.
- Simultaneous events:
  - ex_redirect together with load-use: redirect wins, because the hazard victim in ID is squashed.
  - ex_redirect together with !ihit: the redirect still applies pc_en=1; the IF/ID flush covers the invalid fetch.
  - memcuHALT together with a data miss: DWAIT first, then DRAIN after dhit.
- Register 0 never causes a load-use stall.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt and flush_cnt (STALL_CNT_W each), cleared by RST. stall_cnt increments each cycle pc_en=0 with halt=0. flush_cnt increments each ex_redirect cycle that is not data-stalled. Both saturate at all-ones and freeze once halt=1.
- Undefined: neither port nor the counter logic exists; all other behaviour is unchanged.

Decomposition:
- Shared package cpu_types_pkg gains:
  - hazstate_t enum {RUN, DWAIT, DRAIN, HALTED}
  - regbits_t (5-bit)
  - REG_ZERO constant
- One sub-module, hazard_detect: purely combinational load-use/redirect decode producing lu_stall and redirect_flush.
- The FSM, drain counter and output priority mux live in hazard_controller.

Test Plan:
- Load-use: exMemToReg=1, exWEN=1, exwsel=5, idrsel2=5, ihit=1 → one cycle with pc_en=0, ifW=0, idRST=1, exW=1. The next cycle, with exMemToReg=0, returns all *W=1 and pc_en=1.
- exwsel=0 with idrsel1=0 on a load → no stall, pc_en=1.
- ex_redirect=1 while the load-use condition is also true → ifRST=idRST=1, pc_en=1, ifW=1.
- memcuDRE=1, dhit=0 for 3 cycles with ex_redirect=1 → 3 cycles of all *W=0, pc_en=0. The dhit cycle then shows the redirect flush.
- memcuHALT=1 with HALT_DRAIN=2 → memW stays 1 for the drain cycles. halt=1 exactly 2 cycles after detection, stays 1 with changing inputs, and clears only on an asynchronous RST pulse mid-cycle.
- RST asserted mid DWAIT → outputs go to reset values immediately without waiting for a clock edge. After release, state is RUN.
